// File: rtl/freq_pkg.sv
// freq_pkg -- shared definitions for the equal-precision frequency meter.
//   * default timing constants (reference clock, counter width, gate and
//     timeout lengths, auto-range thresholds)
//   * measurement controller FSM state encoding
//   * result record handed to the frame sender
//   * saturating increment helper used by all nx/nref counters
package freq_pkg;

  localparam int CLK_HZ      = 50_000_000;   // reference clock, informational
  localparam int CNT_W       = 32;
  localparam int GATE0_CYC   = 5_000_000;    // short preset gate, 100 ms
  localparam int GATE1_CYC   = 50_000_000;   // long preset gate, 1 s
  localparam int TIMEOUT_CYC = 100_000_000;  // max wait for an edge in ARM/CLOSE
  localparam int AUTO_LO     = 1000;         // nx below this on gate0 -> gate1
  localparam int AUTO_HI     = 100_000;      // nx above this on gate1 -> gate0

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_CLOSE,
    ST_RESULT
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] nx;
    logic [CNT_W-1:0] nref;
    logic             gate_used;
    logic             timeout;
  } meas_result_t;

  // Counters stick at all-ones instead of wrapping, so an overflowed
  // measurement is recognisable downstream.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// sig_edge_sync -- brings the asynchronous measured signal into the
// in_clk_50M domain and produces a one-cycle pulse per rising edge.
// Ports:
//   in_clk_50M  in   system clock
//   in_clr      in   asynchronous active-high reset
//   sig_async   in   measured signal, asynchronous
//   sig_rise    out  one-cycle pulse, 3 clocks after the input rises
module sig_edge_sync (
  input  logic in_clk_50M,
  input  logic in_clr,
  input  logic sig_async,
  output logic sig_rise
);

  logic s1, s2, s3;

  // s1/s2 form the metastability synchronizer; s3 is the edge-detect delay.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge in_clk_50M or posedge in_clr) begin
    if (in_clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_rise = s2 & ~s3;

endmodule

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl -- sequencing controller of the equal-precision frequency
// meter. Opens the actual gate on a Sig_in rising edge, keeps it open for the
// preset gate length, closes it on the next rising edge, and counts full
// signal periods (nx) and reference clocks (nref) over that same window.
// Ports:
//   in_clk_50M, in_clr         clock, asynchronous active-high reset
//   Sig_in                     measured signal (asynchronous)
//   cfg_gate_sel, cfg_auto     gate choice / auto-range enable, sampled at ARM entry
//   start, continuous          single-shot pulse / free-running restart
//   meas_valid, meas_ready     result handshake to the frame sender
//   nx_cnt, nref_cnt           counts of the held result
//   gate_used, timeout         gate of the held result / result is a timeout
//   busy                       controller not idle
module freq_meas_ctrl
  import freq_pkg::CNT_W, freq_pkg::state_t, freq_pkg::meas_result_t,
         freq_pkg::sat_inc, freq_pkg::ST_IDLE, freq_pkg::ST_ARM,
         freq_pkg::ST_GATE, freq_pkg::ST_CLOSE, freq_pkg::ST_RESULT;
#(
  parameter int GATE0_CYC   = freq_pkg::GATE0_CYC,
  parameter int GATE1_CYC   = freq_pkg::GATE1_CYC,
  parameter int TIMEOUT_CYC = freq_pkg::TIMEOUT_CYC,
  parameter int AUTO_LO     = freq_pkg::AUTO_LO,
  parameter int AUTO_HI     = freq_pkg::AUTO_HI
) (
  input  logic             in_clk_50M,
  input  logic             in_clr,
  input  logic             Sig_in,
  input  logic             cfg_gate_sel,
  input  logic             cfg_auto,
  input  logic             start,
  input  logic             continuous,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] nx_cnt,
  output logic [CNT_W-1:0] nref_cnt,
  output logic             gate_used,
  output logic             timeout,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] nx_q, nx_d, nref_q, nref_d;
  logic [31:0]      timer_q, timer_d, to_q, to_d;
  logic [31:0]      gate_len, timer_inc, to_inc;
  logic             gsel_q, range_q, range_d;
  logic             valid_q, busy_q;
  logic             sig_rise, to_hit, handshake, timeout_d;
  meas_result_t     res_q;

  sig_edge_sync u_sync (
    .in_clk_50M (in_clk_50M),
    .in_clr     (in_clr),
    .sig_async  (Sig_in),
    .sig_rise   (sig_rise)
  );

  assign gate_len  = gsel_q ? 32'(GATE1_CYC) : 32'(GATE0_CYC);
  assign timer_inc = timer_q + 32'd1;
  assign to_inc    = to_q + 32'd1;
  assign to_hit    = (to_inc == 32'(TIMEOUT_CYC));
  assign handshake = valid_q & meas_ready;

  // Next state, counter updates and auto-range decision.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    nx_d      = nx_q;
    nref_d    = nref_q;
    timer_d   = timer_q;
    to_d      = 32'd0;  // timeout counter is zero outside ARM/CLOSE, so it starts clean on entry
    timeout_d = 1'b0;
    range_d   = range_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start || continuous) state_d = ST_ARM;
      end
      ST_ARM: begin
        // Counts are held at zero here: the open edge is not counted, and a
        // timeout from ARM reports 0/0.
        nx_d    = '0;
        nref_d  = '0;
        timer_d = 32'd0;
        to_d    = to_inc;
        if (sig_rise) begin
          state_d = ST_GATE;
        end else if (to_hit) begin
          state_d   = ST_RESULT;
          timeout_d = 1'b1;
        end
      end
      ST_GATE: begin
        nref_d  = sat_inc(nref_q);
        timer_d = timer_inc;
        if (sig_rise) nx_d = sat_inc(nx_q);
        // An edge in the expiry cycle is counted but does not close the gate.
        if (timer_inc == gate_len) state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        nref_d = sat_inc(nref_q);
        to_d   = to_inc;
        if (sig_rise) begin
          nx_d    = sat_inc(nx_q);
          state_d = ST_RESULT;
        end else if (to_hit) begin
          state_d   = ST_RESULT;
          timeout_d = 1'b1;
        end
      end
      ST_RESULT: begin
        if (handshake) begin
          state_d = continuous ? ST_ARM : ST_IDLE;
          if (res_q.timeout) begin
            if (!res_q.gate_used) range_d = 1'b1;
          end else if (!res_q.gate_used && (res_q.nx < CNT_W'(AUTO_LO))) begin
            range_d = 1'b1;
          end else if (res_q.gate_used && (res_q.nx > CNT_W'(AUTO_HI))) begin
            range_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk_50M or posedge in_clr) begin
    if (in_clr) begin
      state_q <= ST_IDLE;
      nx_q    <= '0;
      nref_q  <= '0;
      timer_q <= 32'd0;
      to_q    <= 32'd0;
      gsel_q  <= 1'b0;
      range_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      nx_q    <= nx_d;
      nref_q  <= nref_d;
      timer_q <= timer_d;
      to_q    <= to_d;
      range_q <= range_d;
      busy_q  <= (state_d != ST_IDLE);

      // Config is sampled once per ARM entry; range_d already includes the
      // update from a handshake happening in this same cycle.
      if (state_d == ST_ARM && state_q != ST_ARM)
        gsel_q <= cfg_auto ? range_d : cfg_gate_sel;

      // Result register loads on RESULT entry and is otherwise frozen, so
      // the outputs stay stable for as long as meas_valid is held.
      if (state_d == ST_RESULT && state_q != ST_RESULT) begin
        res_q   <= '{nx: nx_d, nref: nref_d, gate_used: gsel_q, timeout: timeout_d};
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign meas_valid = valid_q;
  assign nx_cnt     = res_q.nx;
  assign nref_cnt   = res_q.nref;
  assign gate_used  = res_q.gate_used;
  assign timeout    = res_q.timeout;
  assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl -- directed bench for freq_meas_ctrl with short gates.
// Sig_in is generated as an exact-period square wave in clock units. The
// model predicts a result from the gate length G and period P alone: the
// gate opens on an edge, counts every edge in the following G clocks, and
// closes on the first edge after that, giving nx = G/P + 1, nref = nx*P.
module tb_freq_meas_ctrl;

  localparam int G0  = 1000;
  localparam int G1  = 10000;
  localparam int TO  = 5000;
  localparam int ALO = 1000;
  localparam int AHI = 100_000;

  logic        clk = 1'b0;
  logic        in_clr, Sig_in, cfg_gate_sel, cfg_auto, start, continuous, meas_ready;
  logic        meas_valid, gate_used, timeout, busy;
  logic [31:0] nx_cnt, nref_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int sig_period = 0;  // 0 = Sig_in held low
  logic m_range = 1'b0;

  always #5 clk = ~clk;

  freq_meas_ctrl #(
    .GATE0_CYC   (G0),
    .GATE1_CYC   (G1),
    .TIMEOUT_CYC (TO),
    .AUTO_LO     (ALO),
    .AUTO_HI     (AHI)
  ) dut (
    .in_clk_50M   (clk),
    .in_clr       (in_clr),
    .Sig_in       (Sig_in),
    .cfg_gate_sel (cfg_gate_sel),
    .cfg_auto     (cfg_auto),
    .start        (start),
    .continuous   (continuous),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .nx_cnt       (nx_cnt),
    .nref_cnt     (nref_cnt),
    .gate_used    (gate_used),
    .timeout      (timeout),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Square-wave generator: period in whole clocks, high half rounded down.
  initial begin
    Sig_in = 1'b0;
    step();
    forever begin
      int p;
      p = sig_period;
      if (p == 0) begin
        Sig_in = 1'b0;
        step();
      end else begin
        Sig_in = 1'b1;
        repeat (p / 2) step();
        Sig_in = 1'b0;
        repeat (p - p / 2) step();
      end
    end
  end

  // Compare process: every cycle a result is presented it must match the
  // model; the model's range register follows the handshake rules.
  always @(negedge clk) begin
    if (in_clr) begin
      m_range = 1'b0;
    end else if (meas_valid) begin
      logic        g;
      logic        e_to;
      int          glen;
      longint      e_nx, e_nref;
      g    = cfg_auto ? m_range : cfg_gate_sel;
      glen = g ? G1 : G0;
      e_to = (sig_period == 0);
      e_nx   = e_to ? 0 : glen / sig_period + 1;
      e_nref = e_to ? 0 : e_nx * sig_period;
      check("model_nx", nx_cnt, e_nx);
      check("model_nref", nref_cnt, e_nref);
      check("model_gate", gate_used, g);
      check("model_timeout", timeout, e_to);
      if (meas_ready) begin
        if (e_to) begin
          if (!g) m_range = 1'b1;
        end else if (!g && e_nx < ALO) begin
          m_range = 1'b1;
        end else if (g && e_nx > AHI) begin
          m_range = 1'b0;
        end
      end
    end
  end

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!meas_valid && n < budget) begin
      step();
      n++;
    end
    check({name, "_valid_seen"}, meas_valid, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic accept(input string name);
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
    check({name, "_valid_drop"}, meas_valid, 0);
  endtask

  task automatic pulse_clr();
    in_clr = 1'b1;
    step();
    in_clr = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_clr = 1'b1;
    cfg_gate_sel = 1'b0;
    cfg_auto = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    meas_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", meas_valid, 0);
    check("rst_nx", nx_cnt, 0);
    check("rst_nref", nref_cnt, 0);
    check("rst_gate", gate_used, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    in_clr = 1'b0;
    step();

    // Period 10: an edge coincides with gate expiry, close on the next one.
    sig_period = 10;
    repeat (40) step();
    pulse_start();
    check("t1_busy", busy, 1);
    wait_valid(3000, "t1");
    check("t1_nx", nx_cnt, 101);
    check("t1_nref", nref_cnt, 1010);
    check("t1_gate", gate_used, 0);
    check("t1_timeout", timeout, 0);
    accept("t1");
    step();
    check("t1_idle", busy, 0);

    // Period 7, result held for 50 cycles with meas_ready low.
    sig_period = 7;
    repeat (40) step();
    pulse_start();
    wait_valid(3000, "t2");
    check("t2_nx", nx_cnt, 143);
    check("t2_nref", nref_cnt, 1001);
    for (int i = 0; i < 50; i++) begin
      step();
      check("t2_hold_valid", meas_valid, 1);
      check("t2_hold_nx", nx_cnt, 143);
      check("t2_hold_nref", nref_cnt, 1001);
    end
    accept("t2");

    // No signal: timeout from ARM on gate0, then auto-range picks gate1.
    pulse_clr();
    cfg_auto = 1'b1;
    sig_period = 0;
    repeat (10) step();
    pulse_start();
    wait_valid(TO + 100, "t3");
    check("t3_timeout", timeout, 1);
    check("t3_nx", nx_cnt, 0);
    check("t3_nref", nref_cnt, 0);
    check("t3_gate", gate_used, 0);
    accept("t3");
    sig_period = 100;
    repeat (300) step();
    pulse_start();
    wait_valid(G1 + 500, "t3b");
    check("t3b_gate", gate_used, 1);
    check("t3b_nx", nx_cnt, 101);
    check("t3b_nref", nref_cnt, 10100);
    check("t3b_timeout", timeout, 0);
    accept("t3b");

    // Continuous auto-range: gate0 result selects gate1 for the next run.
    pulse_clr();
    repeat (300) step();
    continuous = 1'b1;
    wait_valid(G0 + 500, "t4a");
    check("t4a_gate", gate_used, 0);
    check("t4a_nx", nx_cnt, 11);
    check("t4a_nref", nref_cnt, 1100);
    accept("t4a");
    check("t4a_no_gap", busy, 1);
    wait_valid(G1 + 500, "t4b");
    check("t4b_gate", gate_used, 1);
    check("t4b_nx", nx_cnt, 101);
    check("t4b_nref", nref_cnt, 10100);
    continuous = 1'b0;
    accept("t4b");
    step();
    check("t4b_idle", busy, 0);

    // Reset during GATE, then a fresh measurement ignoring extra starts.
    cfg_auto = 1'b0;
    sig_period = 10;
    repeat (40) step();
    pulse_start();
    repeat (200) step();
    check("t5_busy_pre", busy, 1);
    in_clr = 1'b1;
    #1;
    check("t5_clr_busy", busy, 0);
    check("t5_clr_valid", meas_valid, 0);
    check("t5_clr_nx", nx_cnt, 0);
    check("t5_clr_nref", nref_cnt, 0);
    step();
    in_clr = 1'b0;
    step();
    pulse_start();
    repeat (100) step();
    pulse_start();
    repeat (300) step();
    pulse_start();
    wait_valid(3000, "t5");
    check("t5_nx", nx_cnt, 101);
    check("t5_nref", nref_cnt, 1010);
    accept("t5");
    repeat (1200) step();
    check("t5_no_extra_valid", meas_valid, 0);
    check("t5_no_extra_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
